// File: rtl/regfile_pkg.sv
// Shared constants, entry record and fill-state encoding for the register-bank read side.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 16;
  localparam int IDXW  = 4;
  localparam int DEPTH = 2;

  // One buffered operand request. a and b already hold resolved operand values.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IDXW-1:0]  rsrc;
    logic [IDXW-1:0]  rdest;
    logic             use_imm;
  } rd_entry_t;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fill_state_e;

  // Apply a bank write to a stored entry so it keeps tracking the newest
  // architectural value. An immediate in b is never overwritten.
  function automatic rd_entry_t snoop_entry(
    input rd_entry_t        e,
    input logic             wr_en,
    input logic [IDXW-1:0]  wr_idx,
    input logic [WIDTH-1:0] wr_data
  );
    rd_entry_t r;
    r = e;
    if (wr_en && (e.rsrc == wr_idx)) begin
      r.a = wr_data;
    end
    if (wr_en && !e.use_imm && (e.rdest == wr_idx)) begin
      r.b = wr_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_reader_if.sv
// Request and operand handshake bundle between decoder/ALU side and the reader.
// Latency: none (wires only).
// Backpressure: req_ready from the reader, op_ready from the consumer.
interface regfile_reader_if;
  import regfile_pkg::*;

  // Decoder -> reader request channel
  logic             req_valid;
  logic             req_ready;
  logic [IDXW-1:0]  req_rsrc;
  logic [IDXW-1:0]  req_rdest;
  logic             req_use_imm;
  logic [WIDTH-1:0] req_imm;

  // Reader -> ALU operand channel
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDXW-1:0]  op_rdest;

  // Requesting / consuming side (decoder plus ALU)
  modport master (
    output req_valid,
    input  req_ready,
    output req_rsrc,
    output req_rdest,
    output req_use_imm,
    output req_imm,
    input  op_valid,
    output op_ready,
    input  op_a,
    input  op_b,
    input  op_rdest
  );

  // The reader itself
  modport slave (
    input  req_valid,
    output req_ready,
    input  req_rsrc,
    input  req_rdest,
    input  req_use_imm,
    input  req_imm,
    output op_valid,
    input  op_ready,
    output op_a,
    output op_b,
    output op_rdest
  );

endinterface

// File: rtl/regfile_read_mux.sv
// One register-bank read port: NREGS:1 word select with same-cycle write bypass.
// Latency: combinational.
// Backpressure: none.
module regfile_read_mux
  import regfile_pkg::*;
(
  input  logic [NREGS*WIDTH-1:0] i_rf_flat,
  input  logic [IDXW-1:0]        i_idx,
  input  logic                   i_wr_en,
  input  logic [IDXW-1:0]        i_wr_idx,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic [WIDTH-1:0]       o_data
);

  logic [WIDTH-1:0] w_word;
  logic             w_hit;

  // Select the addressed bank word.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i_idx == IDXW'(i)) begin
        w_word = i_rf_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  // The bank only updates at the edge, so a write in flight this cycle wins.
  assign w_hit  = i_wr_en && (i_wr_idx == i_idx);
  assign o_data = w_hit ? i_wr_data : w_word;

endmodule

// File: rtl/regfile_reader.sv
// Register-bank read side: resolves two operands per request into a 2-entry snooping output buffer.
// Latency: 1 cycle (op_valid rises just after the accepting edge); outputs are registered.
// Backpressure: req_ready drops only when both entries are occupied, independent of op_ready.
module regfile_reader
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] rf_flat,
  input  logic                   wr_en,
  input  logic [IDXW-1:0]        wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  regfile_reader_if.slave        bus
);

  // Buffer storage: r_ent0 is always the head, r_ent1 the entry behind it.
  fill_state_e r_state;
  fill_state_e w_state_nxt;
  rd_entry_t   r_ent0;
  rd_entry_t   r_ent1;
  rd_entry_t   w_ent0_nxt;
  rd_entry_t   w_ent1_nxt;

  rd_entry_t        w_new;
  rd_entry_t        w_snp0;
  rd_entry_t        w_snp1;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_push;
  logic             w_pop;

  // Source operand read port
  regfile_read_mux u_mux_rsrc (
    .i_rf_flat (rf_flat),
    .i_idx     (bus.req_rsrc),
    .i_wr_en   (wr_en),
    .i_wr_idx  (wr_idx),
    .i_wr_data (wr_data),
    .o_data    (w_rd_a)
  );

  // Destination operand read port
  regfile_read_mux u_mux_rdest (
    .i_rf_flat (rf_flat),
    .i_idx     (bus.req_rdest),
    .i_wr_en   (wr_en),
    .i_wr_idx  (wr_idx),
    .i_wr_data (wr_data),
    .o_data    (w_rd_b)
  );

  assign bus.req_ready = (r_state != ST_FULL);
  assign bus.op_valid  = (r_state != ST_EMPTY);

  assign w_push = bus.req_valid && bus.req_ready;
  assign w_pop  = bus.op_valid && bus.op_ready;

  // Entry built from the request this cycle; the read ports already include the bypass.
  assign w_new = '{
    a:       w_rd_a,
    b:       bus.req_use_imm ? bus.req_imm : w_rd_b,
    rsrc:    bus.req_rsrc,
    rdest:   bus.req_rdest,
    use_imm: bus.req_use_imm
  };

  // Stored entries as they look after this cycle's bank write.
  assign w_snp0 = snoop_entry(r_ent0, wr_en, wr_idx, wr_data);
  assign w_snp1 = snoop_entry(r_ent1, wr_en, wr_idx, wr_data);

  // Next occupancy and entry contents from push/pop/snoop; invalid slots are left untouched
  // so the outputs of an empty buffer hold their last values.
  always_comb begin
    w_state_nxt = r_state;
    w_ent0_nxt  = r_ent0;
    w_ent1_nxt  = r_ent1;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_ent0_nxt  = w_new;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({w_push, w_pop})
          2'b11: begin
            // Head leaves, new request takes its place.
            w_ent0_nxt = w_new;
          end
          2'b10: begin
            w_ent0_nxt  = w_snp0;
            w_ent1_nxt  = w_new;
            w_state_nxt = ST_FULL;
          end
          2'b01: begin
            w_state_nxt = ST_EMPTY;
          end
          default: begin
            w_ent0_nxt = w_snp0;
          end
        endcase
      end
      ST_FULL: begin
        if (w_pop) begin
          // Survivor moves up to the head, carrying this cycle's snoop.
          w_ent0_nxt  = w_snp1;
          w_state_nxt = ST_ONE;
        end else begin
          w_ent0_nxt = w_snp0;
          w_ent1_nxt = w_snp1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Occupancy and entry registers; reset discards everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ent0  <= w_ent0_nxt;
      r_ent1  <= w_ent1_nxt;
    end
  end

  // Outputs come straight from the head register.
  assign bus.op_a     = r_ent0.a;
  assign bus.op_b     = r_ent0.b;
  assign bus.op_rdest = r_ent0.rdest;

endmodule
